// File: rtl/e_muldiv_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit:
// op encoding, control states, default latencies and HI/LO reset value.
package e_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int          DEFAULT_MULT_CYCLES = 5;
    localparam int          DEFAULT_DIV_CYCLES  = 10;
    localparam logic [31:0] HILO_RESET          = 32'h0000_0000;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_start_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the two divide ops, which use the longer latency.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_muldiv_if.sv
// Bundle between the E-stage datapath and the multiply/divide unit.
// The master side (E stage) drives op/operands; the unit answers with
// start/busy and the architectural HI/LO values.
interface e_muldiv_if;

    logic [2:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic        out_start;
    logic        out_busy;
    logic [31:0] out_hi;
    logic [31:0] out_lo;

    modport master (
        output in_op,
        output in_rs,
        output in_rt,
        input  out_start,
        input  out_busy,
        input  out_hi,
        input  out_lo
    );

    modport slave (
        input  in_op,
        input  in_rs,
        input  in_rt,
        output out_start,
        output out_busy,
        output out_hi,
        output out_lo
    );

endinterface

// File: rtl/e_muldiv_compute.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU, including
// the divide-by-zero and signed-overflow conventions.
module e_muldiv_compute
    import e_muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_rs;
    logic [31:0]        abs_rt;
    logic [31:0]        safe_abs_rt;
    logic [31:0]        safe_rt;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               div_by_zero;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'h0, rs} * {32'h0, rt};

    // Signed divide is done on magnitudes and the signs are reapplied, so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // 0x8000_0000 / -1 falls out naturally: magnitude quotient 0x8000_0000,
    // signs agree so it stays 0x8000_0000, remainder 0.
    assign abs_rs      = rs[31] ? (32'h0 - rs) : rs;
    assign abs_rt      = rt[31] ? (32'h0 - rt) : rt;
    assign div_by_zero = (rt == 32'h0);

    // Divisors are forced to 1 when zero so no X/undefined division is
    // produced; the zero case is overridden in the result mux anyway.
    assign safe_abs_rt = div_by_zero ? 32'h1 : abs_rt;
    assign safe_rt     = div_by_zero ? 32'h1 : rt;

    assign mag_q  = abs_rs / safe_abs_rt;
    assign mag_r  = abs_rs % safe_abs_rt;
    assign quot_s = (rs[31] ^ rt[31]) ? (32'h0 - mag_q) : mag_q;
    assign rem_s  = rs[31] ? (32'h0 - mag_r) : mag_r;

    assign quot_u = rs / safe_rt;
    assign rem_u  = rs % safe_rt;

    // Select the result for the requested op; non-arithmetic ops yield zero.
    always_comb begin
        result = 64'h0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = div_by_zero ? {rs, 32'hFFFF_FFFF} : {rem_s, quot_s};
            MD_DIVU:  result = div_by_zero ? {rs, 32'hFFFF_FFFF} : {rem_u, quot_u};
            default:  result = 64'h0;
        endcase
    end

endmodule

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit. Owns HI/LO, runs MULT/DIV ops with a
// fixed latency (result computed at start, held pending, committed when
// the countdown expires) and handles MTHI/MTLO while idle.
module e_muldiv
    import e_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
)
(
    input  logic  clk,
    input  logic  reset,
    e_muldiv_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e   state_q;
    md_state_e   state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [63:0] pend_q;
    logic [63:0] pend_d;
    logic [31:0] hi_q;
    logic [31:0] hi_d;
    logic [31:0] lo_q;
    logic [31:0] lo_d;
    logic        start;
    logic [63:0] result;

    e_muldiv_compute u_compute (
        .op     (md.in_op),
        .rs     (md.in_rs),
        .rt     (md.in_rt),
        .result (result)
    );

    // State, countdown, pending result and HI/LO registers; active-low sync clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pend_q  <= 64'h0;
            hi_q    <= HILO_RESET;
            lo_q    <= HILO_RESET;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic: accept ops only while idle, count down while busy.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_start_op(md.in_op)) begin
                    start   = 1'b1;
                    pend_d  = result;
                    count_d = is_div_op(md.in_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = ST_BUSY;
                end else if (md.in_op == MD_MTHI) begin
                    hi_d = md.in_rs;
                end else if (md.in_op == MD_MTLO) begin
                    lo_d = md.in_rs;
                end
            end
            ST_BUSY: begin
                if (count_q <= CW'(1)) begin
                    count_d = '0;
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign md.out_start = start;
    assign md.out_busy  = (state_q == ST_BUSY);
    assign md.out_hi    = hi_q;
    assign md.out_lo    = lo_q;

endmodule
